// File: rtl/btn_ctrl_gen.sv
// Push-button front end: 2-flop synchronizers, per-button debounce FSMs with press strobes,
// and the registered 4-bit control word (enable, limit select, colour) feeding the LED shifter.
module btn_ctrl_gen #(
  parameter int N_BTN     = 4,
  parameter int NB_SW     = 4,
  parameter int NB_SEL    = 2,
  parameter int NB_DEB    = 20,
  parameter int DEB_LIMIT = 1000000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_db,
  output logic [N_BTN-1:0] o_pulse,
  output logic [NB_SW-1:0] o_sw
);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} deb_state_t;

  localparam logic [NB_DEB-1:0] LIMIT_M1 = NB_DEB'(DEB_LIMIT - 1);

  // Limit-select step; opposing requests in the same cycle cancel.
  function automatic logic [NB_SEL-1:0] next_sel(input logic [NB_SEL-1:0] sel,
                                                 input logic up, input logic dn);
    logic [NB_SEL-1:0] res;
    res = sel;
    if (up && !dn)
      res = sel + NB_SEL'(1);
    else if (dn && !up)
      res = sel - NB_SEL'(1);
    return res;
  endfunction

  logic [N_BTN-1:0] sync_p0, sync_p1;
  logic [N_BTN-1:0] btn_db, pulse;
  logic [NB_SW-1:0] sw;

  // Stage p0/p1: metastability chain on the raw button levels
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: a level change is accepted after DEB_LIMIT+1 consecutive agreeing samples
  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    deb_state_t        state;
    logic [NB_DEB-1:0] cnt;
    logic              level;
    logic              press;

    always_ff @(posedge clock) begin
      if (i_reset) begin
        state <= STABLE_LO;
        cnt   <= '0;
        level <= 1'b0;
        press <= 1'b0;
      end else begin
        press <= 1'b0;
        case (state)
          STABLE_LO: if (sync_p1[g]) begin
            state <= CHK_HI;
            cnt   <= '0;
          end
          CHK_HI: if (!sync_p1[g]) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == LIMIT_M1) begin
            state <= STABLE_HI;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + NB_DEB'(1);
          end
          STABLE_HI: if (!sync_p1[g]) begin
            state <= CHK_LO;
            cnt   <= '0;
          end
          CHK_LO: if (sync_p1[g]) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == LIMIT_M1) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + NB_DEB'(1);
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign btn_db[g] = level;
    assign pulse[g]  = press;
  end

  // Stage p2: control word consumes the registered press strobes
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sw <= '0;
    end else begin
      sw[0]          <= sw[0] ^ pulse[0];
      sw[NB_SEL:1]   <= next_sel(sw[NB_SEL:1], pulse[1], pulse[2]);
      sw[NB_SW-1]    <= sw[NB_SW-1] ^ pulse[3];
    end
  end

  assign o_btn_db = btn_db;
  assign o_pulse  = pulse;
  assign o_sw     = sw;

endmodule

// File: doc/btn_ctrl_gen.md
Name: btn_ctrl_gen

Overview:
Input-side companion to the switch-controlled LED shifter. It synchronizes and debounces four push-buttons and produces one-cycle press pulses. From those pulses it maintains a registered 4-bit control word with the same bit layout the shifter reads from its switches:
- bit0: enable
- bits[2:1]: limit select
- bit3: RGB colour

On the board top level it sits between the raw buttons and the shifter's switch input.

Parameters:
N_BTN, 4, number of push-buttons (fixed at 4 for the control-word mapping)
NB_SW, 4, control word width
NB_SEL, 2, limit-select field width
NB_DEB, 20, debounce counter width
DEB_LIMIT, 1000000, consecutive stable cycles required to accept a level change (2 <= DEB_LIMIT <= 2**NB_DEB - 1)

Ports:
clock  input  1  system clock
i_reset  input  1  reset, synchronous, active-high
i_btn  input  N_BTN  raw asynchronous push-button levels, 1 = pressed
o_btn_db  output  N_BTN  debounced button levels
o_pulse  output  N_BTN  one-cycle press strobe per button
o_sw  output  NB_SW  control word to the LED shifter

Behaviour:
- Interface: one clock (clock); reset i_reset is synchronous and active-high. All state is updated only on the rising edge of clock.
- Reset values: synchronizers 0, debounce FSMs in STABLE_LO, counters 0, o_btn_db = 0, o_pulse = 0, o_sw = 4'b0000. Reset takes priority over every other event.
- Synchronizer: a 2-flop chain per button. The FSM sees only the second flop (s_btn).
- Debounce FSM, one per button, with independent counter cnt[NB_DEB-1:0]. States: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: if s_btn = 1, go to CHK_HI with cnt = 0.
  - CHK_HI: if s_btn = 0 (glitch), go to STABLE_LO with cnt = 0. Else if cnt = DEB_LIMIT-1, go to STABLE_HI and set level to 1. Else cnt++.
  - STABLE_HI and CHK_LO mirror the above for release.
  - cnt never wraps. It is cleared on every state entry.
- Latency: a clean press held steady makes o_btn_db rise on the (DEB_LIMIT+3)th rising edge, counting the first edge that samples i_btn = 1 as edge 1. Release timing is symmetric.
- o_pulse[i] is registered. It is high for exactly the one cycle in which o_btn_db[i] is first 1 after a 0->1 transition. Releases produce no pulse. Holding a button produces a single pulse.
- Control word update: applied on the edge after the pulse, so o_sw changes 1 cycle after o_pulse.
  - pulse[0]: toggle o_sw[0] (enable).
  - pulse[1]: o_sw[2:1] + 1 mod 4 (3 -> 0 wrap).
  - pulse[2]: o_sw[2:1] - 1 mod 4 (0 -> 3 wrap).
  - pulse[3]: toggle o_sw[3] (colour).
- Simultaneous pulses:
  - Independent fields update together.
  - pulse[1] and pulse[2] in the same cycle leave o_sw[2:1] unchanged.
- Reset mid-operation: any partial debounce is discarded. A button held through reset deassertion is re-debounced from STABLE_LO and produces a fresh pulse after DEB_LIMIT+3 edges.
- Widths: all compares are unsigned, NB_DEB bits wide. DEB_LIMIT is truncated to NB_DEB bits only if it violates its allowed range (illegal configuration; not supported).

Test Plan:
Use DEB_LIMIT = 4 in simulation.
1. Reset: hold i_reset = 1 for 3 cycles with i_btn = 4'hF -> o_sw = 0, o_btn_db = 0, o_pulse = 0 throughout.
2. Clean press: i_btn[0] 0->1, held 20 cycles -> o_btn_db[0] rises on edge 7; o_pulse[0] high for exactly 1 cycle; o_sw = 4'b0001 one cycle later; no further pulse while held; release -> o_btn_db[0] falls 7 edges after release with no pulse.
3. Bounce: i_btn[1] toggles 1,0,1,0,1 with 2-cycle widths, then stays high -> exactly one o_pulse[1], timed DEB_LIMIT+3 edges after the final rising edge; o_sw[2:1] goes 0 -> 1.
4. Wrap: four debounced presses of btn1 -> o_sw[2:1] sequence 1,2,3,0. From 0, one btn2 press -> 3.
5. Simultaneous: btn1 and btn2 pressed together with identical timing -> both pulses in the same cycle; o_sw[2:1] unchanged. btn0 and btn3 together -> o_sw[0] and o_sw[3] both toggle in the same cycle.
6. Reset mid-debounce: btn3 held; assert i_reset while the FSM is in CHK_HI with cnt = 2; release reset with btn3 still held -> no pulse before reset; single o_pulse[3] exactly 7 edges after reset deassertion; o_sw[3] = 1.
